// File: rtl/neuron_layer_pkg.sv
// Shared types and constants for the neuron layer buffer.
package neuron_layer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int DEFAULT_DATA_WIDTH  = 16;
   localparam int DEFAULT_NUM_NEURONS = 4;

   // Largest value representable in a signed word of the given width.
   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // Smallest value representable in a signed word of the given width.
   function automatic logic signed [63:0] sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/neuron_sat_add.sv
// Combinational signed adder that clamps to the word range instead of wrapping.
module neuron_sat_add
   import neuron_layer_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] sum
);

   localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(sat_min(DATA_WIDTH));

   logic [DATA_WIDTH:0] wide_sum;

   // Add with one guard bit; disagreeing top two bits means the result overflowed.
   always_comb begin
      wide_sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
         sum = wide_sum[DATA_WIDTH] ? MIN_V : MAX_V;
      end else begin
         sum = wide_sum[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/neuron_layer_buffer.sv
// Activation register bank for one layer: addressed overwrite/accumulate loads,
// per-neuron loaded mask, and a valid/ready read-out stream with optional ReLU.
module neuron_layer_buffer
   import neuron_layer_pkg::*;
#(
   parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH  = 16,
   parameter int RELU_EN     = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              load_en,
   input  logic                              load_mode,
   input  logic [ADDR_WIDTH-1:0]             load_address,
   input  logic [DATA_WIDTH-1:0]             load_value,
   input  logic                              stream_start,
   input  logic                              out_ready,
   output logic [NUM_NEURONS*DATA_WIDTH-1:0] values,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_last,
   output logic                              stream_done,
   output logic                              busy,
   output logic                              layer_full,
   output logic                              addr_err,
   output logic                              load_drop
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
   localparam logic [ADDR_WIDTH:0] NUM_N_EXT = (ADDR_WIDTH + 1)'(NUM_NEURONS);

   state_t                       state_reg, state_next;
   logic [IDX_W-1:0]             idx_reg, idx_next;
   logic signed [DATA_WIDTH-1:0] neuron_reg [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]       loaded_mask_reg, loaded_mask_next;
   logic                         stream_done_reg, stream_done_next;
   logic                         addr_err_reg, load_drop_reg;

   logic                         addr_in_range, load_ok, last_xfer;
   logic [IDX_W-1:0]             load_idx;
   logic signed [DATA_WIDTH-1:0] acc_operand, acc_result, write_value, beat_value;

   assign addr_in_range = {1'b0, load_address} < NUM_N_EXT;
   assign load_ok       = load_en && (state_reg == IDLE) && addr_in_range;
   assign load_idx      = load_address[IDX_W-1:0];
   assign acc_operand   = neuron_reg[load_idx];
   assign write_value   = load_mode ? acc_result : load_value;
   assign beat_value    = neuron_reg[idx_reg];
   assign last_xfer     = (state_reg == STREAM) && out_ready && (idx_reg == LAST_IDX);

   // Only one load is accepted per cycle, so a single adder serves every neuron.
   neuron_sat_add #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_sat_add (
      .a   (acc_operand),
      .b   (load_value),
      .sum (acc_result)
   );

   // Neuron storage: accepted loads write the addressed word.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            neuron_reg[i] <= '0;
         end
      end else if (load_ok) begin
         neuron_reg[load_idx] <= write_value;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_values
         assign values[gi*DATA_WIDTH +: DATA_WIDTH] = neuron_reg[gi];
      end
   endgenerate

   // Loaded mask: set by accepted loads, cleared when a full read-out completes.
   always_comb begin
      loaded_mask_next = loaded_mask_reg;
      if (load_ok) begin
         loaded_mask_next[load_idx] = 1'b1;
      end
      if (last_xfer) begin
         loaded_mask_next = '0;
      end
   end

   // Stream next-state and beat outputs; loads in IDLE never block a start.
   always_comb begin
      state_next       = state_reg;
      idx_next         = idx_reg;
      stream_done_next = 1'b0;
      out_valid        = 1'b0;
      out_data         = '0;
      out_last         = 1'b0;
      busy             = 1'b0;
      case (state_reg)
         IDLE: begin
            if (stream_start) begin
               state_next = STREAM;
               idx_next   = '0;
            end
         end
         STREAM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (idx_reg == LAST_IDX);
            out_data  = ((RELU_EN != 0) && beat_value[DATA_WIDTH-1]) ? '0 : beat_value;
            if (out_ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next       = IDLE;
                  stream_done_next = 1'b1;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control registers and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         loaded_mask_reg <= '0;
         stream_done_reg <= 1'b0;
         addr_err_reg    <= 1'b0;
         load_drop_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         idx_reg         <= idx_next;
         loaded_mask_reg <= loaded_mask_next;
         stream_done_reg <= stream_done_next;
         addr_err_reg    <= load_en && (state_reg == IDLE) && !addr_in_range;
         load_drop_reg   <= load_en && (state_reg == STREAM);
      end
   end

   assign stream_done = stream_done_reg;
   assign addr_err    = addr_err_reg;
   assign load_drop   = load_drop_reg;
   assign layer_full  = &loaded_mask_reg;

endmodule

// File: tb/tb_neuron_layer_buffer.sv
// Scoreboard bench for neuron_layer_buffer: stimulus pushes expected beats,
// an independent negedge monitor pops and compares every transferred beat.
module tb_neuron_layer_buffer;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int AW = 16;

   logic           clk = 1'b0;
   logic           reset, load_en, load_mode, stream_start, out_ready;
   logic [AW-1:0]  load_address;
   logic [W-1:0]   load_value;
   logic [N*W-1:0] values;
   logic           out_valid, out_last, stream_done, busy, layer_full, addr_err, load_drop;
   logic [W-1:0]   out_data;

   always #5 clk = ~clk;

   neuron_layer_buffer #(
      .NUM_NEURONS(N), .DATA_WIDTH(W), .ADDR_WIDTH(AW), .RELU_EN(1)
   ) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_mode(load_mode),
      .load_address(load_address), .load_value(load_value),
      .stream_start(stream_start), .out_ready(out_ready), .values(values),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .stream_done(stream_done), .busy(busy), .layer_full(layer_full),
      .addr_err(addr_err), .load_drop(load_drop)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: plain signed integers and a loaded flag per neuron.
   int model_n[N];
   bit model_mask[N];

   logic [W:0] exp_q[$];
   logic [W:0] mon_item;
   bit         last_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int to_s16(input int v);
      logic signed [15:0] t;
      t = 16'(v);
      return int'(t);
   endfunction

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [N*W-1:0] model_values();
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = 16'(model_n[i]);
      return r;
   endfunction

   function automatic logic model_full();
      logic f;
      f = 1'b1;
      for (int i = 0; i < N; i++) f = f & model_mask[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         model_n[i]    = 0;
         model_mask[i] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one load in IDLE, update the model and check its visible effects.
   task automatic do_load(input int addr, input int val, input bit mode);
      load_en      = 1'b1;
      load_mode    = mode;
      load_address = AW'(addr);
      load_value   = W'(val);
      tick();
      load_en = 1'b0;
      if (addr < N) begin
         if (mode) model_n[addr] = clamp16(model_n[addr] + to_s16(val));
         else      model_n[addr] = to_s16(val);
         model_mask[addr] = 1'b1;
      end
      $display("load addr=%0d val=%h mode=%0d -> values=%h", addr, W'(val), mode, values);
      check("load_values", values, model_values());
      check("load_addr_err", addr_err, (addr >= N));
      check("load_drop_idle", load_drop, 1'b0);
      check("load_layer_full", layer_full, model_full());
   endtask

   // Expected beats of a complete read-out, ReLU applied.
   task automatic push_stream();
      logic [W:0] item;
      for (int i = 0; i < N; i++) begin
         item[W-1:0] = (model_n[i] < 0) ? '0 : 16'(model_n[i]);
         item[W]     = (i == N - 1);
         exp_q.push_back(item);
      end
   endtask

   task automatic start_stream();
      stream_start = 1'b1;
      push_stream();
      tick();
      stream_start = 1'b0;
   endtask

   // Wait for stream_done; optional random back-pressure.
   task automatic wait_done(input bit random_ready);
      int k;
      k = 0;
      while (!stream_done && k < 200) begin
         if (random_ready) out_ready = 1'($urandom % 2);
         tick();
         k++;
      end
      if (!stream_done) check("stream_done_timeout", 64'd0, 64'd1);
      for (int i = 0; i < N; i++) model_mask[i] = 1'b0;
      out_ready = 1'b0;
      check("post_stream_busy", busy, 1'b0);
      check("post_stream_full", layer_full, 1'b0);
      check("post_stream_values", values, model_values());
   endtask

   // Monitor: compare transferred beats and the stream_done timing.
   always @(negedge clk) begin
      check("stream_done_pulse", stream_done, last_prev);
      last_prev = 1'b0;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("beat_unexpected", 64'd1, 64'd0);
         end else begin
            mon_item = exp_q.pop_front();
            $display("beat data=%h last=%0d (exp %h/%0d)", out_data, out_last, mon_item[W-1:0], mon_item[W]);
            check("beat_data", out_data, mon_item[W-1:0]);
            check("beat_last", out_last, mon_item[W]);
            last_prev = mon_item[W];
         end
      end
   end

   initial begin
      reset = 1'b1; load_en = 1'b0; load_mode = 1'b0; load_address = '0;
      load_value = '0; stream_start = 1'b0; out_ready = 1'b0;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      check("rst_values", values, 64'd0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_full", layer_full, 1'b0);
      check("rst_data", out_data, 16'd0);
      check("rst_last", out_last, 1'b0);
      check("rst_addr_err", addr_err, 1'b0);
      check("rst_load_drop", load_drop, 1'b0);

      // Overwrite, then saturating accumulates at both rails and through zero.
      do_load(2, 'h1234, 1'b0);
      check("addr2_field", values[47:32], 16'h1234);
      do_load(0, 'h7FF0, 1'b0);
      do_load(0, 'h0020, 1'b1);
      check("sat_pos", values[15:0], 16'h7FFF);
      do_load(1, 'h8001, 1'b0);
      do_load(1, 'hFFFE, 1'b1);
      check("sat_neg", values[31:16], 16'h8000);
      do_load(3, 'h0010, 1'b0);
      do_load(3, 'hFFF0, 1'b1);
      check("acc_zero", values[63:48], 16'h0000);

      // Out-of-range address: one-cycle addr_err, no state change.
      do_load(4, 'h5555, 1'b0);
      tick();
      check("addr_err_clear", addr_err, 1'b0);

      // Full layer, stalled start then drain.
      do_load(0, 5, 1'b0);
      do_load(1, 'hFFFE, 1'b0);
      do_load(2, 0, 1'b0);
      do_load(3, 7, 1'b0);
      check("layer_full_set", layer_full, 1'b1);
      start_stream();
      for (int k = 0; k < 3; k++) begin
         check("stall_valid", out_valid, 1'b1);
         check("stall_data", out_data, 16'd5);
         check("stall_busy", busy, 1'b1);
         tick();
      end
      out_ready = 1'b1;
      wait_done(1'b0);
      check("persist_n1", values[31:16], 16'hFFFE);

      // Loads during a stream are dropped; a second start is ignored.
      start_stream();
      load_en = 1'b1; load_mode = 1'b0; load_address = AW'(1); load_value = 16'h1111;
      tick();
      load_en = 1'b0;
      check("drop_pulse", load_drop, 1'b1);
      check("drop_no_addr_err", addr_err, 1'b0);
      out_ready = 1'b1;
      tick();
      check("drop_clear", load_drop, 1'b0);
      stream_start = 1'b1;
      load_en = 1'b1; load_address = AW'(5);
      tick();
      stream_start = 1'b0;
      load_en = 1'b0;
      check("drop_oor_pulse", load_drop, 1'b1);
      check("drop_oor_no_addr_err", addr_err, 1'b0);
      wait_done(1'b0);

      // Reset after two beats: abort, clear everything, no stream_done.
      start_stream();
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      out_ready = 1'b0;
      check("beats_left_at_reset", 64'(exp_q.size()), 64'd2);
      tick();
      reset = 1'b0;
      exp_q.delete();
      model_reset();
      check("abort_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_values", values, 64'd0);
      check("abort_full", layer_full, 1'b0);
      tick();
      check("abort_no_done", stream_done, 1'b0);
      do_load(0, 'h0101, 1'b0);
      do_load(3, 'h8000, 1'b0);
      start_stream();
      out_ready = 1'b1;
      wait_done(1'b0);

      // Randomised loads and back-pressured streams.
      for (int it = 0; it < 6; it++) begin
         for (int j = 0; j < 8; j++) begin
            do_load(int'($urandom_range(0, 5)), int'($urandom % 65536), 1'($urandom % 2));
         end
         start_stream();
         wait_done(1'b1);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_layer_buffer.md
Name: neuron_layer_buffer

Overview:
Parametrised register bank holding the activations of one fully-connected layer: NUM_NEURONS signed words of DATA_WIDTH bits, written by address.
Extends the fixed 2x16 neuron layer with:
- accumulate-on-load (saturating);
- a per-neuron loaded mask and layer_full flag;
- a valid/ready streaming read-out with optional ReLU, feeding the next layer's MAC engine.
Sits between the weight/MAC datapath (writer) and the next layer (stream consumer).

Parameters:
NUM_NEURONS, 4, number of neuron registers (>=2).
DATA_WIDTH, 16, signed word width.
ADDR_WIDTH, 16, width of load_address.
RELU_EN, 1, 1 = stream output clamps negative values to 0; 0 = raw values.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
load_en  in  1  write request, one cycle per write.
load_mode  in  1  0 = overwrite, 1 = saturating accumulate into stored value.
load_address  in  ADDR_WIDTH  target neuron index.
load_value  in  DATA_WIDTH  signed write/accumulate operand.
stream_start  in  1  pulse: begin read-out of all neurons.
out_ready  in  1  consumer ready.
values  out  NUM_NEURONS*DATA_WIDTH  all stored values; neuron i at [i*DATA_WIDTH +: DATA_WIDTH].
out_valid  out  1  stream beat valid.
out_data  out  DATA_WIDTH  stream beat (ReLU applied if RELU_EN).
out_last  out  1  high with the beat of neuron NUM_NEURONS-1.
stream_done  out  1  one-cycle pulse after the last beat transfers.
busy  out  1  high in STREAM state.
layer_full  out  1  all loaded-mask bits set.
addr_err  out  1  one-cycle pulse: load_en with load_address >= NUM_NEURONS.
load_drop  out  1  one-cycle pulse: load_en while busy.

Behaviour:
Reset (synchronous, reset high at an edge):
- all neuron registers, loaded mask, stream index, stream_done, addr_err and load_drop go to 0;
- state goes to IDLE; out_valid = 0, out_last = 0, out_data = 0, busy = 0, layer_full = 0;
- reset overrides every other input in the same cycle.

Load (accepted only in IDLE):
- An in-range load_en updates neuron[load_address] at the edge; visible on values the next cycle.
- Overwrite: neuron <= load_value.
- Accumulate: neuron <= sat(neuron + load_value), signed, computed at DATA_WIDTH+1 bits, clamped to [-2^(W-1), 2^(W-1)-1].
- Either mode sets loaded_mask[addr].
Load rejection:
- Out-of-range address: no state change; addr_err pulses the next cycle.
- load_en while busy: no state change; load_drop pulses the next cycle.
- If both apply, only load_drop pulses.

Stream FSM, states IDLE and STREAM:
- IDLE -> STREAM on stream_start; idx <= 0. If load_en and stream_start arrive together in IDLE, the load is applied first and stream_start is accepted in the same edge. stream_start in STREAM is ignored.
- In STREAM: out_valid = 1, out_data = f(neuron[idx]) with f = ReLU if RELU_EN, out_last = (idx == NUM_NEURONS-1), busy = 1.
- Latency: stream_start at edge t -> first beat valid in cycle t+1.
- Transfer happens on out_valid && out_ready. out_data and out_last are held stable while out_ready is low; values are frozen because loads are blocked.
- On a non-last transfer: idx++.
- On the last transfer: -> IDLE, loaded mask cleared, stream_done pulses in the following cycle. Neuron values persist.
- No wrap: idx never exceeds NUM_NEURONS-1.
- Reset mid-stream: abort to IDLE with the full reset values; no stream_done.

Decomposition:
Package neuron_layer_pkg holds:
- state enum {IDLE, STREAM};
- default DATA_WIDTH / NUM_NEURONS constants;
- saturation min/max constant functions of the width.
One sub-module, neuron_sat_add: combinational signed saturating adder, parametrised by DATA_WIDTH, shared by all neuron write paths through a single instance (one write per cycle).

Test Plan:
1. N=4, W=16: reset; overwrite addr 2 = 0x1234 -> next cycle values[47:32]=0x1234, all other fields 0, layer_full=0.
2. Overwrite addr0=0x7FF0, accumulate +0x0020 -> 0x7FFF. Overwrite addr1=0x8001, accumulate 0xFFFE (-2) -> 0x8000. Overwrite addr3=0x0010, accumulate 0xFFF0 -> 0x0000.
3. load_en to addr 4 (value 0x5555) -> addr_err pulses one cycle, values unchanged, mask unchanged.
4. Load {5, 0xFFFE, 0, 7} into addrs 0..3 -> layer_full=1. Then stream_start (RELU_EN=1) with out_ready low 3 cycles then high:
   - first beat out_data=5 held stable across the stall;
   - beats 5, 0, 0, 7; out_last only on the 4th beat;
   - stream_done pulses once; layer_full=0; values still {5, 0xFFFE, 0, 7}.
5. During a stream, load_en addr1 = 0x1111 -> load_drop pulses, neuron1 unchanged; a second stream_start mid-stream does not restart idx.
6. Reset asserted after 2 transferred beats -> next cycle out_valid=0, busy=0, all values 0, no stream_done; a new stream_start then streams from idx 0.
